// File: rtl/if_prefetch_unit_if.sv
// Fetch-unit bundle: instruction-memory req/ack port, MEM-stage redirect and decode-side valid/stall.
// The master side is the prefetch unit; the slave side is the memory/pipeline environment.
interface if_prefetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus4_o,
        input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, stall_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_plus4_o,
        output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, stall_i
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch: one outstanding imem request feeding a DEPTH-entry FIFO of {pc+4, instr}.
// Acked word is visible to decode next cycle; stall holds the head, redirect flushes FIFO and in-flight fetch.
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk_i,
    input  logic rst_i,
    if_prefetch_unit_if.master fe
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    pending_pc;
    logic [CW-1:0]  count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    mem_instr [DEPTH];
    logic [31:0]    mem_pc4   [DEPTH];

    logic           valid;
    logic           push;
    logic           pop;
    logic [31:0]    pc_plus4;
    logic [CW-1:0]  count_after;

    assign valid       = (count != '0);
    assign pop         = valid & ~fe.stall_i & ~fe.redirect_i;
    assign push        = (state == WAIT) & fe.imem_ack_i & ~fe.redirect_i;
    assign pc_plus4    = fetch_pc + 32'd4;
    assign count_after = count + CW'(push) - CW'(pop);

    assign fe.imem_req_o  = (state != IDLE);
    assign fe.imem_addr_o = fetch_pc;
    assign fe.valid_o     = valid;
    assign fe.instr_o     = valid ? mem_instr[rd_ptr] : 32'd0;
    assign fe.pc_plus4_o  = valid ? mem_pc4[rd_ptr]   : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (fe.redirect_i) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count_after;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end

            case (state)
                IDLE: begin
                    if (fe.redirect_i)
                        fetch_pc <= fe.redirect_pc_i;
                    else if (count < CW'(DEPTH))
                        state <= WAIT;
                end
                WAIT: begin
                    if (fe.redirect_i) begin
                        if (fe.imem_ack_i) begin
                            fetch_pc <= fe.redirect_pc_i;
                            state    <= IDLE;
                        end else begin
                            // Request must stay stable until acked; remember the target.
                            pending_pc <= fe.redirect_pc_i;
                            state      <= DROP;
                        end
                    end else if (fe.imem_ack_i) begin
                        fetch_pc <= pc_plus4;
                        state    <= (count_after < CW'(DEPTH)) ? WAIT : IDLE;
                    end
                end
                DROP: begin
                    if (fe.imem_ack_i) begin
                        fetch_pc <= fe.redirect_i ? fe.redirect_pc_i : pending_pc;
                        state    <= IDLE;
                    end else if (fe.redirect_i) begin
                        pending_pc <= fe.redirect_pc_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && push) begin
            mem_instr[wr_ptr] <= fe.imem_data_i;
            mem_pc4[wr_ptr]   <= pc_plus4;
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: stimulus pushes expected {pc+4, instr} entries,
// a negedge monitor pops and compares on every consumed head entry.
module tb_if_prefetch_unit;
    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    if_prefetch_unit_if bus();

    if_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .fe    (bus)
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] h(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign bus.imem_data_i = h(bus.imem_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_entry(input logic [31:0] pc4, input logic [31:0] addr);
        exp_t e;
        e.pc4   = pc4;
        e.instr = h(addr);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check("sb_consumed", 32'(sb.size()), 32'd0);
        rst_i             = 1'b0;
        bus.imem_ack_i    = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        tick();
        sb.delete();
        rst_i = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_i && bus.valid_o && !bus.stall_i && !bus.redirect_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got pc_plus4 %h, expected no output", bus.pc_plus4_o);
            end else begin
                e = sb.pop_front();
                check("sb_pc_plus4", bus.pc_plus4_o, e.pc4);
                check("sb_instr", bus.instr_o, e.instr);
            end
        end
    end

    initial begin
        rst_i             = 1'b0;
        bus.imem_ack_i    = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        tick();
        tick();
        check("rst_req",   32'(bus.imem_req_o), 32'd0);
        check("rst_addr",  bus.imem_addr_o, 32'h0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_instr", bus.instr_o, 32'h0);
        check("rst_pc4",   bus.pc_plus4_o, 32'h0);
        rst_i = 1'b1;

        // Streaming with ack tied high.
        bus.imem_ack_i = 1'b1;
        expect_entry(32'h4, 32'h0);
        expect_entry(32'h8, 32'h4);
        expect_entry(32'hC, 32'h8);
        tick();
        check("t1_req",    32'(bus.imem_req_o), 32'd1);
        check("t1_addr0",  bus.imem_addr_o, 32'h0);
        check("t1_valid0", 32'(bus.valid_o), 32'd0);
        tick();
        check("t1_addr4",  bus.imem_addr_o, 32'h4);
        check("t1_valid1", 32'(bus.valid_o), 32'd1);
        tick();
        check("t1_addr8",  bus.imem_addr_o, 32'h8);
        tick();
        check("t1_addrC",  bus.imem_addr_o, 32'hC);
        bus.imem_ack_i = 1'b0;
        tick();
        check("t1_drained", 32'(bus.valid_o), 32'd0);
        check("t1_hold",    bus.imem_addr_o, 32'hC);
        do_reset();

        // Fill under stall, then drain and resume.
        bus.imem_ack_i = 1'b1;
        bus.stall_i    = 1'b1;
        expect_entry(32'h04, 32'h00);
        expect_entry(32'h08, 32'h04);
        expect_entry(32'h0C, 32'h08);
        expect_entry(32'h10, 32'h0C);
        expect_entry(32'h14, 32'h10);
        repeat (5) tick();
        check("t2_full_req",   32'(bus.imem_req_o), 32'd0);
        check("t2_full_valid", 32'(bus.valid_o), 32'd1);
        check("t2_head",       bus.pc_plus4_o, 32'h4);
        tick();
        check("t2_idle_req",   32'(bus.imem_req_o), 32'd0);
        bus.stall_i = 1'b0;
        tick();
        tick();
        check("t2_resume_req",  32'(bus.imem_req_o), 32'd1);
        check("t2_resume_addr", bus.imem_addr_o, 32'h10);
        tick();
        check("t2_next_addr",   bus.imem_addr_o, 32'h14);
        bus.imem_ack_i = 1'b0;
        repeat (3) tick();
        check("t2_empty", 32'(bus.valid_o), 32'd0);
        do_reset();

        // Delayed ack holds the address.
        bus.imem_ack_i = 1'b1;
        expect_entry(32'h4, 32'h0);
        expect_entry(32'h8, 32'h4);
        expect_entry(32'hC, 32'h8);
        repeat (3) tick();
        check("t3_addr", bus.imem_addr_o, 32'h8);
        bus.imem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stable_addr", bus.imem_addr_o, 32'h8);
            check("t3_stable_req",  32'(bus.imem_req_o), 32'd1);
        end
        bus.imem_ack_i = 1'b1;
        tick();
        check("t3_valid", 32'(bus.valid_o), 32'd1);
        check("t3_addr2", bus.imem_addr_o, 32'hC);
        bus.imem_ack_i = 1'b0;
        tick();
        check("t3_one_entry", 32'(bus.valid_o), 32'd0);
        do_reset();

        // Redirect while waiting, ack two cycles later is dropped.
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        tick();
        check("t4_drop_req",  32'(bus.imem_req_o), 32'd1);
        check("t4_drop_addr", bus.imem_addr_o, 32'h0);
        bus.redirect_i = 1'b0;
        tick();
        check("t4_drop_addr2", bus.imem_addr_o, 32'h0);
        bus.imem_ack_i = 1'b1;
        tick();
        check("t4_idle_req", 32'(bus.imem_req_o), 32'd0);
        check("t4_no_valid", 32'(bus.valid_o), 32'd0);
        expect_entry(32'h104, 32'h100);
        tick();
        check("t4_new_req",  32'(bus.imem_req_o), 32'd1);
        check("t4_new_addr", bus.imem_addr_o, 32'h100);
        tick();
        check("t4_valid", 32'(bus.valid_o), 32'd1);
        bus.imem_ack_i = 1'b0;
        tick();
        do_reset();

        // Redirect coinciding with ack and an unstalled head, two entries buffered.
        bus.imem_ack_i = 1'b1;
        bus.stall_i    = 1'b1;
        repeat (3) tick();
        check("t5_two_valid", 32'(bus.valid_o), 32'd1);
        check("t5_two_addr",  bus.imem_addr_o, 32'h8);
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        tick();
        check("t5_flush_valid", 32'(bus.valid_o), 32'd0);
        check("t5_flush_req",   32'(bus.imem_req_o), 32'd0);
        check("t5_flush_addr",  bus.imem_addr_o, 32'h200);
        bus.redirect_i = 1'b0;
        expect_entry(32'h204, 32'h200);
        tick();
        check("t5_new_req",  32'(bus.imem_req_o), 32'd1);
        check("t5_new_addr", bus.imem_addr_o, 32'h200);
        tick();
        check("t5_valid", 32'(bus.valid_o), 32'd1);
        bus.imem_ack_i = 1'b0;
        tick();
        do_reset();

        // Reset in the middle of DROP.
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h300;
        tick();
        check("t6_in_drop", 32'(bus.imem_req_o), 32'd1);
        bus.redirect_i = 1'b0;
        rst_i          = 1'b0;
        tick();
        rst_i = 1'b1;
        check("t6_rst_req",   32'(bus.imem_req_o), 32'd0);
        check("t6_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t6_rst_addr",  bus.imem_addr_o, 32'h0);
        tick();
        check("t6_restart_req",  32'(bus.imem_req_o), 32'd1);
        check("t6_restart_addr", bus.imem_addr_o, 32'h0);
        bus.imem_ack_i = 1'b1;
        expect_entry(32'h4, 32'h0);
        tick();
        check("t6_valid", 32'(bus.valid_o), 32'd1);
        bus.imem_ack_i = 1'b0;
        tick();
        do_reset();

        // A second redirect during DROP replaces the pending target.
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        tick();
        bus.redirect_pc_i = 32'h140;
        tick();
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b1;
        tick();
        check("t7_idle_req", 32'(bus.imem_req_o), 32'd0);
        check("t7_addr",     bus.imem_addr_o, 32'h140);
        bus.imem_ack_i = 1'b0;
        tick();
        check("t7_req",      32'(bus.imem_req_o), 32'd1);
        do_reset();

        // PC+4 wraps at the top of the address space.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        check("t8_idle_req", 32'(bus.imem_req_o), 32'd0);
        check("t8_addr",     bus.imem_addr_o, 32'hFFFF_FFFC);
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b1;
        expect_entry(32'h0, 32'hFFFF_FFFC);
        tick();
        check("t8_req_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("t8_wrap_addr", bus.imem_addr_o, 32'h0);
        check("t8_valid",     32'(bus.valid_o), 32'd1);
        check("t8_pc4",       bus.pc_plus4_o, 32'h0);
        bus.imem_ack_i = 1'b0;
        tick();
        tick();
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
